// File: rtl/bus_dma_arbiter_if.sv
// Shared cartridge-bus signal bundle for bus_dma_arbiter.
// The master modport is the arbiter side; the slave modport is the CPU/DMA/bus side.
interface bus_dma_arbiter_if;
  // Audio DMA
  logic        adma_req;
  logic [15:0] adma_addr;
  logic [2:0]  adma_bank;
  logic [7:0]  adma_data;
  logic        adma_valid;
  logic        adma_ovf;

  // Video DMA
  logic        vdma_req;
  logic [15:0] vdma_addr;
  logic [2:0]  vdma_bank;
  logic        vdma_gnt;
  logic [7:0]  vdma_data;

  // CPU
  logic [15:0] cpu_addr;
  logic [2:0]  cpu_bank;
  logic        cpu_rdy;

  // Cartridge bus
  logic [15:0] bus_addr;
  logic [2:0]  bus_bank;
  logic        bus_rd;
  logic [7:0]  bus_din;

  logic [1:0]  owner;

  modport master (
    input  adma_req, adma_addr, adma_bank,
    input  vdma_req, vdma_addr, vdma_bank,
    input  cpu_addr, cpu_bank,
    input  bus_din,
    output adma_data, adma_valid, adma_ovf,
    output vdma_gnt, vdma_data,
    output cpu_rdy,
    output bus_addr, bus_bank, bus_rd,
    output owner
  );

  modport slave (
    output adma_req, adma_addr, adma_bank,
    output vdma_req, vdma_addr, vdma_bank,
    output cpu_addr, cpu_bank,
    output bus_din,
    input  adma_data, adma_valid, adma_ovf,
    input  vdma_gnt, vdma_data,
    input  cpu_rdy,
    input  bus_addr, bus_bank, bus_rd,
    input  owner
  );
endinterface

// File: rtl/bus_dma_arbiter.sv
// Cartridge-bus arbiter between CPU, audio DMA and video DMA.
// Define BUS_ARB_FAIR_SLOT_EN to enable VDMA burst limiting with a forced FAIR CPU slot.
module bus_dma_arbiter #(
  parameter int unsigned MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  bus_dma_arbiter_if.master bus
);

  if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_max_burst
    $error("bus_dma_arbiter: MAX_BURST must be in 1..15");
  end

  typedef enum logic [1:0] {
    ST_CPU  = 2'd0,
    ST_ADMA = 2'd1,
    ST_VDMA = 2'd2
`ifdef BUS_ARB_FAIR_SLOT_EN
    ,
    ST_FAIR = 2'd3
`endif
  } state_e;

  state_e      state_q, state_d;
  logic        adma_pend_q, adma_pend_d;
  logic        adma_ovf_q, adma_ovf_d;
  logic [7:0]  adma_data_q, adma_data_d;
  logic        adma_valid_q, adma_valid_d;
  logic [7:0]  vdma_data_q, vdma_data_d;
  logic        vdma_gnt_q, vdma_gnt_d;
  logic        vdma_ok;

`ifdef BUS_ARB_FAIR_SLOT_EN
  localparam logic [3:0] BurstMax = 4'(MAX_BURST);
  // Counts VDMA slots already granted in the current run, including the live one.
  logic [3:0]  burst_cnt_q, burst_cnt_d;
`endif

  // ---------------------------------------------------------------------------
  // Next-state and capture logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    adma_pend_d  = adma_pend_q;
    adma_ovf_d   = adma_ovf_q;
    adma_data_d  = adma_data_q;
    adma_valid_d = 1'b0;
    vdma_data_d  = vdma_data_q;
    vdma_gnt_d   = 1'b0;
`ifdef BUS_ARB_FAIR_SLOT_EN
    burst_cnt_d  = burst_cnt_q;
    vdma_ok      = bus.vdma_req && (burst_cnt_q < BurstMax);
`else
    vdma_ok      = bus.vdma_req;
`endif

    if (ce) begin
      if (bus.adma_req && adma_pend_q) begin
        adma_ovf_d = 1'b1;
      end

      // Closing ADMA drops the pending flag; a request colliding with it is lost.
      if (state_q == ST_ADMA) begin
        adma_pend_d  = 1'b0;
        adma_data_d  = bus.bus_din;
        adma_valid_d = 1'b1;
      end else begin
        adma_pend_d  = adma_pend_q | bus.adma_req;
      end

      if (state_q == ST_VDMA) begin
        vdma_data_d = bus.bus_din;
        vdma_gnt_d  = 1'b1;
      end

      if (adma_pend_d) begin
        state_d = ST_ADMA;
      end else if (vdma_ok) begin
        state_d = ST_VDMA;
`ifdef BUS_ARB_FAIR_SLOT_EN
      end else if (bus.vdma_req) begin
        state_d = ST_FAIR;
`endif
      end else begin
        state_d = ST_CPU;
      end

`ifdef BUS_ARB_FAIR_SLOT_EN
      burst_cnt_d = (state_d == ST_VDMA) ? burst_cnt_q + 4'd1 : 4'd0;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_CPU;
      adma_pend_q  <= 1'b0;
      adma_ovf_q   <= 1'b0;
      adma_data_q  <= '0;
      adma_valid_q <= 1'b0;
      vdma_data_q  <= '0;
      vdma_gnt_q   <= 1'b0;
`ifdef BUS_ARB_FAIR_SLOT_EN
      burst_cnt_q  <= '0;
`endif
    end else begin
      state_q      <= state_d;
      adma_pend_q  <= adma_pend_d;
      adma_ovf_q   <= adma_ovf_d;
      adma_data_q  <= adma_data_d;
      adma_valid_q <= adma_valid_d;
      vdma_data_q  <= vdma_data_d;
      vdma_gnt_q   <= vdma_gnt_d;
`ifdef BUS_ARB_FAIR_SLOT_EN
      burst_cnt_q  <= burst_cnt_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Bus steering from the registered owner
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.bus_addr = bus.cpu_addr;
    bus.bus_bank = bus.cpu_bank;
    bus.bus_rd   = 1'b0;
    bus.cpu_rdy  = 1'b1;
    case (state_q)
      ST_ADMA: begin
        bus.bus_addr = bus.adma_addr;
        bus.bus_bank = bus.adma_bank;
        bus.bus_rd   = 1'b1;
        bus.cpu_rdy  = 1'b0;
      end
      ST_VDMA: begin
        bus.bus_addr = bus.vdma_addr;
        bus.bus_bank = bus.vdma_bank;
        bus.bus_rd   = 1'b1;
        bus.cpu_rdy  = 1'b0;
      end
      default: begin
        bus.bus_addr = bus.cpu_addr;
        bus.bus_bank = bus.cpu_bank;
        bus.bus_rd   = 1'b0;
        bus.cpu_rdy  = 1'b1;
      end
    endcase
  end

  assign bus.owner      = state_q;
  assign bus.adma_data  = adma_data_q;
  assign bus.adma_valid = adma_valid_q;
  assign bus.adma_ovf   = adma_ovf_q;
  assign bus.vdma_data  = vdma_data_q;
  assign bus.vdma_gnt   = vdma_gnt_q;

endmodule

// File: tb/tb_bus_dma_arbiter.sv
// Directed self-checking bench for bus_dma_arbiter (MAX_BURST=8).
// Burst/FAIR expectations follow BUS_ARB_FAIR_SLOT_EN when it is defined.
module tb_bus_dma_arbiter;

  logic clk;
  logic reset;
  logic ce;
  int   checks;
  int   errors;

  bus_dma_arbiter_if bif();

  bus_dma_arbiter #(.MAX_BURST(8)) dut (
    .clk  (clk),
    .reset(reset),
    .ce   (ce),
    .bus  (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    checks++; if (bif.owner !== 2'd0) begin errors++; $display("FAIL reset_owner got %0d exp 0", bif.owner); end
    checks++; if (bif.cpu_rdy !== 1'b1) begin errors++; $display("FAIL reset_cpu_rdy got %b exp 1", bif.cpu_rdy); end
    checks++; if (bif.bus_rd !== 1'b0) begin errors++; $display("FAIL reset_bus_rd got %b exp 0", bif.bus_rd); end
    checks++; if (bif.adma_valid !== 1'b0) begin errors++; $display("FAIL reset_adma_valid got %b exp 0", bif.adma_valid); end
    checks++; if (bif.vdma_gnt !== 1'b0) begin errors++; $display("FAIL reset_vdma_gnt got %b exp 0", bif.vdma_gnt); end
    checks++; if (bif.adma_data !== 8'h00) begin errors++; $display("FAIL reset_adma_data got %h exp 00", bif.adma_data); end
    checks++; if (bif.vdma_data !== 8'h00) begin errors++; $display("FAIL reset_vdma_data got %h exp 00", bif.vdma_data); end
    checks++; if (bif.adma_ovf !== 1'b0) begin errors++; $display("FAIL reset_adma_ovf got %b exp 0", bif.adma_ovf); end
    checks++; if (bif.bus_addr !== 16'h1234) begin errors++; $display("FAIL reset_bus_addr got %h exp 1234", bif.bus_addr); end
    checks++; if (bif.bus_bank !== 3'd1) begin errors++; $display("FAIL reset_bus_bank got %0d exp 1", bif.bus_bank); end
  endtask

  task automatic test_adma_read();
    bif.adma_req  = 1'b1;
    bif.adma_addr = 16'h4000;
    bif.adma_bank = 3'd2;
    bif.bus_din   = 8'hA5;
    step();
    bif.adma_req = 1'b0;
    checks++; if (bif.owner !== 2'd1) begin errors++; $display("FAIL adma_owner got %0d exp 1", bif.owner); end
    checks++; if (bif.bus_rd !== 1'b1) begin errors++; $display("FAIL adma_bus_rd got %b exp 1", bif.bus_rd); end
    checks++; if (bif.cpu_rdy !== 1'b0) begin errors++; $display("FAIL adma_cpu_rdy got %b exp 0", bif.cpu_rdy); end
    checks++; if (bif.bus_addr !== 16'h4000) begin errors++; $display("FAIL adma_bus_addr got %h exp 4000", bif.bus_addr); end
    checks++; if (bif.bus_bank !== 3'd2) begin errors++; $display("FAIL adma_bus_bank got %0d exp 2", bif.bus_bank); end
    checks++; if (bif.adma_valid !== 1'b0) begin errors++; $display("FAIL adma_valid_early got %b exp 0", bif.adma_valid); end
    step();
    checks++; if (bif.adma_valid !== 1'b1) begin errors++; $display("FAIL adma_valid got %b exp 1", bif.adma_valid); end
    checks++; if (bif.adma_data !== 8'hA5) begin errors++; $display("FAIL adma_data got %h exp a5", bif.adma_data); end
    checks++; if (bif.owner !== 2'd0) begin errors++; $display("FAIL adma_return_owner got %0d exp 0", bif.owner); end
    checks++; if (bif.cpu_rdy !== 1'b1) begin errors++; $display("FAIL adma_return_cpu_rdy got %b exp 1", bif.cpu_rdy); end
    step();
    checks++; if (bif.adma_valid !== 1'b0) begin errors++; $display("FAIL adma_valid_width got %b exp 0", bif.adma_valid); end
    checks++; if (bif.adma_data !== 8'hA5) begin errors++; $display("FAIL adma_data_hold got %h exp a5", bif.adma_data); end
  endtask

  task automatic test_ce_hold();
    bif.adma_req = 1'b1;
    bif.bus_din  = 8'h11;
    step();
    bif.adma_req = 1'b0;
    ce = 1'b0;
    bif.bus_din = 8'h3C;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (bif.owner !== 2'd1) begin errors++; $display("FAIL ce_hold_owner got %0d exp 1", bif.owner); end
      checks++; if (bif.adma_valid !== 1'b0) begin errors++; $display("FAIL ce_hold_valid got %b exp 0", bif.adma_valid); end
    end
    ce = 1'b1;
    step();
    ce = 1'b0;
    checks++; if (bif.adma_valid !== 1'b1) begin errors++; $display("FAIL ce_close_valid got %b exp 1", bif.adma_valid); end
    checks++; if (bif.adma_data !== 8'h3C) begin errors++; $display("FAIL ce_close_data got %h exp 3c", bif.adma_data); end
    step();
    checks++; if (bif.adma_valid !== 1'b0) begin errors++; $display("FAIL ce_strobe_width got %b exp 0", bif.adma_valid); end
    checks++; if (bif.owner !== 2'd0) begin errors++; $display("FAIL ce_idle_owner got %0d exp 0", bif.owner); end
    checks++; if (bif.adma_data !== 8'h3C) begin errors++; $display("FAIL ce_idle_data got %h exp 3c", bif.adma_data); end
    ce = 1'b1;
    step();
  endtask

  task automatic test_vdma_burst();
    logic [1:0] seq [10];
    logic [1:0] prev;
    logic [7:0] din;
`ifdef BUS_ARB_FAIR_SLOT_EN
    seq = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd2};
`else
    seq = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2};
`endif
    bif.vdma_req  = 1'b1;
    bif.vdma_addr = 16'h8000;
    bif.vdma_bank = 3'd5;
    prev = 2'd0;
    for (int k = 0; k < 10; k++) begin
      din = 8'(16 + k);
      bif.bus_din = din;
      step();
      checks++; if (bif.owner !== seq[k]) begin errors++; $display("FAIL burst_owner[%0d] got %0d exp %0d", k, bif.owner, seq[k]); end
      checks++; if (bif.vdma_gnt !== (prev == 2'd2)) begin errors++; $display("FAIL burst_gnt[%0d] got %b exp %b", k, bif.vdma_gnt, prev == 2'd2); end
      if (prev == 2'd2) begin
        checks++; if (bif.vdma_data !== din) begin errors++; $display("FAIL burst_data[%0d] got %h exp %h", k, bif.vdma_data, din); end
      end
      if (seq[k] == 2'd2) begin
        checks++; if (bif.bus_addr !== 16'h8000 || bif.bus_bank !== 3'd5 || bif.bus_rd !== 1'b1 || bif.cpu_rdy !== 1'b0) begin
          errors++; $display("FAIL burst_vdma_bus[%0d] got %h/%0d/%b/%b exp 8000/5/1/0", k, bif.bus_addr, bif.bus_bank, bif.bus_rd, bif.cpu_rdy);
        end
      end else begin
        checks++; if (bif.bus_addr !== 16'h1234 || bif.bus_rd !== 1'b0 || bif.cpu_rdy !== 1'b1) begin
          errors++; $display("FAIL burst_fair_bus[%0d] got %h/%b/%b exp 1234/0/1", k, bif.bus_addr, bif.bus_rd, bif.cpu_rdy);
        end
      end
      prev = seq[k];
    end
    bif.vdma_req = 1'b0;
    step();
    checks++; if (bif.owner !== 2'd0) begin errors++; $display("FAIL burst_end_owner got %0d exp 0", bif.owner); end
    checks++; if (bif.vdma_gnt !== 1'b1) begin errors++; $display("FAIL burst_end_gnt got %b exp 1", bif.vdma_gnt); end
    step();
  endtask

  task automatic test_adma_mid_burst();
    logic [1:0] exp;
    bif.vdma_req = 1'b1;
    for (int g = 0; g < 3; g++) begin
      step();
      checks++; if (bif.owner !== 2'd2) begin errors++; $display("FAIL mid_grant%0d_owner got %0d exp 2", g + 1, bif.owner); end
    end
    bif.adma_req  = 1'b1;
    bif.adma_addr = 16'h4100;
    bif.bus_din   = 8'h5A;
    step();
    bif.adma_req = 1'b0;
    checks++; if (bif.owner !== 2'd1) begin errors++; $display("FAIL mid_adma_owner got %0d exp 1", bif.owner); end
    checks++; if (bif.vdma_gnt !== 1'b1) begin errors++; $display("FAIL mid_grant3_gnt got %b exp 1", bif.vdma_gnt); end
    bif.bus_din = 8'h77;
    // Restarted burst: eight VDMA slots, then FAIR when slot limiting is built in.
    for (int j = 0; j < 9; j++) begin
      step();
`ifdef BUS_ARB_FAIR_SLOT_EN
      exp = (j == 8) ? 2'd3 : 2'd2;
`else
      exp = 2'd2;
`endif
      checks++; if (bif.owner !== exp) begin errors++; $display("FAIL mid_resume_owner[%0d] got %0d exp %0d", j, bif.owner, exp); end
      if (j == 0) begin
        checks++; if (bif.adma_valid !== 1'b1 || bif.adma_data !== 8'h77) begin
          errors++; $display("FAIL mid_adma_valid got %b/%h exp 1/77", bif.adma_valid, bif.adma_data);
        end
      end
    end
    bif.vdma_req = 1'b0;
    step();
    step();
    checks++; if (bif.owner !== 2'd0) begin errors++; $display("FAIL mid_end_owner got %0d exp 0", bif.owner); end
  endtask

  task automatic test_adma_overflow();
    int valids;
    checks++; if (bif.adma_ovf !== 1'b0) begin errors++; $display("FAIL ovf_pre got %b exp 0", bif.adma_ovf); end
    bif.vdma_req = 1'b1;
    step();
    checks++; if (bif.owner !== 2'd2) begin errors++; $display("FAIL ovf_vdma_owner got %0d exp 2", bif.owner); end
    bif.adma_req = 1'b1;
    step();
    valids = 0;
    checks++; if (bif.owner !== 2'd1) begin errors++; $display("FAIL ovf_adma_owner got %0d exp 1", bif.owner); end
    checks++; if (bif.adma_ovf !== 1'b0) begin errors++; $display("FAIL ovf_first_req got %b exp 0", bif.adma_ovf); end
    step();
    bif.adma_req = 1'b0;
    bif.vdma_req = 1'b0;
    checks++; if (bif.adma_ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", bif.adma_ovf); end
    if (bif.adma_valid === 1'b1) valids++;
    for (int i = 0; i < 5; i++) begin
      step();
      if (bif.adma_valid === 1'b1) valids++;
    end
    checks++; if (valids != 1) begin errors++; $display("FAIL ovf_valid_count got %0d exp 1", valids); end
    checks++; if (bif.adma_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", bif.adma_ovf); end
    checks++; if (bif.owner !== 2'd0) begin errors++; $display("FAIL ovf_end_owner got %0d exp 0", bif.owner); end
  endtask

  task automatic test_reset_abort();
    bif.adma_req = 1'b1;
    step();
    bif.adma_req = 1'b0;
    checks++; if (bif.owner !== 2'd1) begin errors++; $display("FAIL rst_adma_owner got %0d exp 1", bif.owner); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (bif.adma_valid !== 1'b0) begin errors++; $display("FAIL rst_adma_valid got %b exp 0", bif.adma_valid); end
    checks++; if (bif.owner !== 2'd0) begin errors++; $display("FAIL rst_adma_owner0 got %0d exp 0", bif.owner); end
    checks++; if (bif.cpu_rdy !== 1'b1) begin errors++; $display("FAIL rst_adma_cpu_rdy got %b exp 1", bif.cpu_rdy); end
    checks++; if (bif.adma_ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf_clear got %b exp 0", bif.adma_ovf); end
    step();
    checks++; if (bif.adma_valid !== 1'b0 || bif.owner !== 2'd0) begin
      errors++; $display("FAIL rst_adma_lost got %b/%0d exp 0/0", bif.adma_valid, bif.owner);
    end
    bif.vdma_req = 1'b1;
    step();
    checks++; if (bif.owner !== 2'd2) begin errors++; $display("FAIL rst_vdma_owner got %0d exp 2", bif.owner); end
    bif.vdma_req = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (bif.vdma_gnt !== 1'b0 || bif.owner !== 2'd0) begin
      errors++; $display("FAIL rst_vdma_abort got %b/%0d exp 0/0", bif.vdma_gnt, bif.owner);
    end
  endtask

  task automatic test_simultaneous();
    bif.adma_req = 1'b1;
    bif.vdma_req = 1'b1;
    bif.bus_din  = 8'hC3;
    step();
    bif.adma_req = 1'b0;
    checks++; if (bif.owner !== 2'd1) begin errors++; $display("FAIL sim_first_owner got %0d exp 1", bif.owner); end
    step();
    bif.vdma_req = 1'b0;
    bif.bus_din  = 8'h96;
    checks++; if (bif.owner !== 2'd2) begin errors++; $display("FAIL sim_second_owner got %0d exp 2", bif.owner); end
    checks++; if (bif.adma_valid !== 1'b1 || bif.adma_data !== 8'hC3) begin
      errors++; $display("FAIL sim_adma_data got %b/%h exp 1/c3", bif.adma_valid, bif.adma_data);
    end
    step();
    checks++; if (bif.owner !== 2'd0) begin errors++; $display("FAIL sim_end_owner got %0d exp 0", bif.owner); end
    checks++; if (bif.vdma_gnt !== 1'b1 || bif.vdma_data !== 8'h96) begin
      errors++; $display("FAIL sim_vdma_data got %b/%h exp 1/96", bif.vdma_gnt, bif.vdma_data);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    ce = 1'b1;
    bif.adma_req  = 1'b0;
    bif.adma_addr = 16'h0000;
    bif.adma_bank = 3'd0;
    bif.vdma_req  = 1'b0;
    bif.vdma_addr = 16'h0000;
    bif.vdma_bank = 3'd0;
    bif.cpu_addr  = 16'h1234;
    bif.cpu_bank  = 3'd1;
    bif.bus_din   = 8'h00;

    test_reset();
    test_adma_read();
    test_ce_hold();
    test_vdma_burst();
    test_adma_mid_burst();
    test_adma_overflow();
    test_reset_abort();
    test_simultaneous();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_dma_arbiter.md
BUS_DMA_ARBITER -- requirements
Module: bus_dma_arbiter

Interface
REQ-001 SHALL have parameter MAX_BURST, default 8, max consecutive VDMA grants before a forced CPU slot (range 1..15).
REQ-002 SHALL have port clk, input, 1, system clock.
REQ-003 SHALL have port reset, input, 1, synchronous, active-high.
REQ-004 SHALL have port ce, input, 1, CPU clock enable; all state advances only on clk edges with ce=1.
REQ-005 SHALL have port adma_req, input, 1, audio DMA read request; the request is a one-ce pulse.
REQ-006 SHALL have ports adma_addr and adma_bank, input, 16 and 3, audio DMA address and bank.
REQ-007 SHALL have ports adma_data and adma_valid, output, 8 and 1, captured sample byte and one-clk valid strobe.
REQ-008 SHALL have ports vdma_req, vdma_addr and vdma_bank, input, 1, 16 and 3; vdma_req is level, held until done.
REQ-009 SHALL have ports vdma_gnt and vdma_data, output, 1 and 8, one-clk grant strobe and captured byte.
REQ-010 SHALL have ports cpu_addr and cpu_bank, input, 16 and 3, CPU address.
REQ-011 SHALL have port cpu_rdy, output, 1; 0 stalls the CPU for the current ce.
REQ-012 SHALL have ports bus_addr, bus_bank, bus_rd and bus_din: output 16, output 3, output 1 and input 8, the shared cartridge bus.
REQ-013 SHALL have ports owner and adma_ovf, output, 2 and 1: current bus owner (0 CPU, 1 ADMA, 2 VDMA, 3 FAIR) and sticky lost-request flag.

Function
REQ-014 SHALL implement a registered FSM with states CPU, ADMA, VDMA and FAIR; owner SHALL equal the state encoding.
REQ-015 SHALL latch adma_req into adma_pend on any ce; adma_pend SHALL clear when the ADMA state completes.
REQ-016 SHALL set adma_ovf when adma_req arrives while adma_pend=1; adma_ovf SHALL clear only on reset.
REQ-017 SHALL select the next state on each ce by priority: adma_pend (including a same-cycle adma_req) > vdma_req (if burst_cnt<MAX_BURST) > CPU.
REQ-018 SHALL occupy the ADMA, VDMA and FAIR states for exactly one ce each; after each, the state SHALL be re-arbitrated.
REQ-019 In ADMA, SHALL drive bus_addr/bus_bank from adma_addr/adma_bank with bus_rd=1 and cpu_rdy=0; adma_data SHALL capture bus_din on the closing ce edge; adma_valid SHALL pulse on that same edge for one clk.
REQ-020 In VDMA, SHALL drive vdma_addr/vdma_bank with bus_rd=1 and cpu_rdy=0; vdma_data and vdma_gnt SHALL behave as adma_data and adma_valid.
REQ-021 In CPU and FAIR, SHALL drive cpu_addr/cpu_bank with bus_rd=0 and cpu_rdy=1.
REQ-022 SHALL count consecutive VDMA grants in a 4-bit burst_cnt; any non-VDMA state SHALL clear it.
REQ-023 The VDMA request SHALL be blocked when burst_cnt=MAX_BURST; with vdma_req still high and no ADMA pending, the FSM SHALL enter FAIR.
REQ-024 An ADMA granted mid-burst SHALL not clear burst_cnt beyond REQ-022, and the burst SHALL resume after it.
REQ-025 Outputs SHALL hold their values while ce=0.

Reset
REQ-026 On reset, SHALL set state CPU, adma_pend=0, adma_ovf=0, burst_cnt=0, adma_data=0, vdma_data=0, adma_valid=0, vdma_gnt=0, owner=0 and cpu_rdy=1.
REQ-027 A reset during ADMA or VDMA SHALL abort the cycle with no valid or grant strobe; the request SHALL be lost.

Configuration
REQ-028 With macro BUS_ARB_FAIR_SLOT_EN defined, burst limiting and the FAIR state SHALL behave per REQ-022 to REQ-024.
REQ-029 Without BUS_ARB_FAIR_SLOT_EN, burst_cnt and FAIR SHALL be absent, vdma_req SHALL never be blocked, and owner SHALL never be 3.

Verification
REQ-030 With adma_req pulsed, adma_addr=16'h4000 and bus_din=8'hA5, the bench SHALL see one ADMA ce with bus_rd=1 and cpu_rdy=0, then adma_data=8'hA5 and a one-clk adma_valid.
REQ-031 With vdma_req held and MAX_BURST=8 under FAIR_SLOT_EN, the bench SHALL see the owner sequence 2,2,2,2,2,2,2,2,3,2, repeating.
REQ-032 With adma_req during a VDMA burst at grant 3, the bench SHALL see the next ce owner=1, then VDMA resume with burst_cnt continuing from 0 after the ADMA state.
REQ-033 With two adma_req pulses on consecutive ce while in VDMA, the bench SHALL see adma_ovf=1 and exactly one adma_valid.
REQ-034 With reset asserted during ADMA, the bench SHALL see no adma_valid, owner=0 and cpu_rdy=1 on the next clk.
REQ-035 With simultaneous adma_req and vdma_req from CPU state, the bench SHALL see ADMA first, then VDMA.
